vedic_mac_acc: RTL and testbench
================================

Name: vedic_mac_acc

Overview:
- Sequential accumulation stage placed directly downstream of the 4x4 combinational multiplier array.
- Consumes a stream of 8-bit products over a valid/ready handshake and sums LEN of them, or fewer if in_last arrives early.
- Presents one registered dot-product result, with an overflow flag and a term count, over a second valid/ready handshake.
- Gives the combinational multiplier a clocked, backpressure-aware consumer.

Parameters:
- PW, 8, product input width; matches 2x the 4-bit operand width.
- ACC_W, 12, accumulator/result width. The sum is kept modulo 2^ACC_W.
- LEN, 4, maximum number of products per result (>=1).
- CW, $clog2(LEN+1), term-counter width (derived; do not override).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream product valid.
- in_ready  output  1  block can accept a product this cycle.
- in_prod  input  PW  product from the multiplier, unsigned.
- in_last  input  1  this product ends the current group (sampled only on an input handshake).
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  ACC_W  accumulated sum, registered.
- out_ovf  output  1  sticky: a carry out of ACC_W occurred during this group.
- out_cnt  output  CW  number of products summed into out_sum.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. On a rising clk edge with rst=1, the next state is the reset state regardless of any other input. rst asserted mid-group or mid-hold discards the partial or pending result; no output handshake occurs.
- Reset values: state=ACC, acc=0, cnt=0, ovf=0, out_valid=0, out_sum=0, out_ovf=0, out_cnt=0. in_ready=1 from the first cycle after reset release.
- State ACC:
  - in_ready=1, out_valid=0.
  - Input handshake = in_valid & in_ready.
  - On a handshake: acc <= (acc + in_prod) mod 2^ACC_W; ovf <= ovf | carry-out; cnt <= cnt+1.
  - in_prod is zero-extended to ACC_W+1 before the add.
  - If the handshake has in_last=1 or cnt+1==LEN, go to OUT. The final sum, ovf and cnt+1 are loaded into out_sum/out_ovf/out_cnt on the same edge.
  - in_valid=0 holds all state; there is no timeout.
- State OUT:
  - out_valid=1, in_ready=0. Upstream stalls and in_prod/in_last are ignored.
  - out_sum/out_ovf/out_cnt stay stable until out_ready=1.
  - On an output handshake: return to ACC with acc=0, cnt=0, ovf=0, out_valid=0 next cycle.
  - No same-cycle bypass. The first product of the next group is accepted no earlier than the cycle after the output handshake.
- Latency: out_valid rises 1 cycle after the final input handshake. Minimum 1 bubble cycle per group, so peak throughput is LEN products per LEN+1 cycles.
- in_last on the very first product gives out_cnt=1 and out_sum=in_prod.
- in_last=1 coinciding with cnt+1==LEN is treated as a single termination.
- Wrap-around: out_sum is the low ACC_W bits of the true sum. out_ovf is set if any partial sum exceeded 2^ACC_W-1. Once set, it stays set for the group.
- out_valid must not depend combinationally on out_ready. in_ready depends only on state.

Test Plan:
- Reset then 4 back-to-back products 6,9,24,80 (2x3,3x3,8x3,8x10) with out_ready=1 -> out_valid 1 cycle after 4th accept; out_sum=119, out_cnt=4, out_ovf=0; in_ready=0 for exactly 1 cycle.
- Products 196,196,196,196 (14x14) -> out_sum=784, out_ovf=0. Rerun with ACC_W=9 -> out_sum=272, out_ovf=1.
- Early termination: 15 then 30 with in_last=1 on 30 -> out_sum=45, out_cnt=2. Next group starts from acc=0.
- Backpressure: out_ready=0 for 5 cycles while in_valid=1 with new products -> in_ready=0 throughout; out_sum/out_cnt stable; no product consumed until the cycle after the out_ready handshake.
- Gapped input: in_valid toggles 1,0,0,1,0,1,1 across products 1,2,3,4 -> out_sum=10, out_cnt=4; idle cycles change nothing.
- rst=1 for one cycle after 2 accepted products (acc=50), then 4 products of 1 -> out_sum=4, out_cnt=4, out_ovf=0; no out_valid before reset completion.

Source files
------------

// File: rtl/vedic_mac_acc.sv
// Accumulator stage behind the 4x4 multiplier array. It sums up to LEN unsigned products
// per group and presents one registered result over a valid/ready handshake.
module vedic_mac_acc #(
  parameter int unsigned PW    = 8,
  parameter int unsigned ACC_W = 12,
  parameter int unsigned LEN   = 4,
  parameter int unsigned CW    = $clog2(LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PW-1:0]    in_prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic [CW-1:0]    out_cnt
);

  localparam logic [0:0] StAcc = 1'b0;
  localparam logic [0:0] StOut = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic             oovf_q, oovf_d;
  logic [CW-1:0]    ocnt_q, ocnt_d;

  logic [ACC_W:0]   prod_ext;
  logic [ACC_W:0]   sum_ext;
  logic [CW-1:0]    cnt_inc;
  logic             in_fire;
  logic             grp_done;

  assign in_ready  = (state_q == StAcc);
  assign out_valid = (state_q == StOut);
  assign out_sum   = sum_q;
  assign out_ovf   = oovf_q;
  assign out_cnt   = ocnt_q;

  // Top bit of the widened add is the carry out of the ACC_W-bit accumulator.
  assign prod_ext = {{(ACC_W + 1 - PW){1'b0}}, in_prod};
  assign sum_ext  = {1'b0, acc_q} + prod_ext;
  assign cnt_inc  = cnt_q + CW'(1);
  assign in_fire  = in_valid & in_ready;
  assign grp_done = in_last | (cnt_inc == CW'(LEN));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    sum_d   = sum_q;
    oovf_d  = oovf_q;
    ocnt_d  = ocnt_q;
    unique case (state_q)
      StAcc: begin
        if (in_fire) begin
          acc_d = sum_ext[ACC_W-1:0];
          ovf_d = ovf_q | sum_ext[ACC_W];
          cnt_d = cnt_inc;
          if (grp_done) begin
            state_d = StOut;
            sum_d   = sum_ext[ACC_W-1:0];
            oovf_d  = ovf_q | sum_ext[ACC_W];
            ocnt_d  = cnt_inc;
          end
        end
      end
      StOut: begin
        if (out_ready) begin
          state_d = StAcc;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = StAcc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StAcc;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      sum_q   <= '0;
      oovf_q  <= 1'b0;
      ocnt_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      sum_q   <= sum_d;
      oovf_q  <= oovf_d;
      ocnt_q  <= ocnt_d;
    end
  end

endmodule

// File: tb/tb_vedic_mac_acc.sv
// Bench for vedic_mac_acc: a 12-bit and a 9-bit accumulator share one stimulus stream and are
// compared against a group-level model plus a table of known dot products.
module tb_vedic_mac_acc;

  localparam int LEN = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_prod;
  logic        in_last;
  logic        out_ready;
  logic        in_ready, out_valid, out_ovf;
  logic [11:0] out_sum;
  logic [2:0]  out_cnt;
  logic        in_ready9, out_valid9, out_ovf9;
  logic [8:0]  out_sum9;
  logic [2:0]  out_cnt9;

  always #5 clk = ~clk;

  vedic_mac_acc #(.PW(8), .ACC_W(12), .LEN(LEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_ovf(out_ovf), .out_cnt(out_cnt)
  );

  vedic_mac_acc #(.PW(8), .ACC_W(9), .LEN(LEN)) dut9 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready9), .in_prod(in_prod),
    .in_last(in_last), .out_valid(out_valid9), .out_ready(out_ready), .out_sum(out_sum9),
    .out_ovf(out_ovf9), .out_cnt(out_cnt9)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Group-level model: products of the open group, and the result being offered.
  bit          m_known = 1'b0;
  bit          m_pend = 1'b0;
  int unsigned m_grp[$];
  int unsigned m_sum12, m_sum9, m_cnt;
  bit          m_ovf12, m_ovf9;

  typedef struct packed {
    logic [2:0]      n;
    logic [3:0][7:0] prod;
    logic [3:0]      last;
    logic [11:0]     sum;
    logic            ovf;
    logic [2:0]      cnt;
    logic [8:0]      sum9;
    logic            ovf9;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic group_result(input int unsigned w, output int unsigned sum, output bit ovf);
    int unsigned total = 0;
    ovf = 1'b0;
    foreach (m_grp[i]) begin
      total += m_grp[i];
      if (total >= (32'd1 << w)) ovf = 1'b1;
    end
    sum = total % (32'd1 << w);
  endtask

  // Compare outputs against the model, advance the model with the current inputs, clock once.
  task automatic cyc();
    if (m_known) begin
      chk("in_ready", int'(in_ready), int'(!m_pend));
      chk("out_valid", int'(out_valid), int'(m_pend));
      chk("out_valid9", int'(out_valid9), int'(m_pend));
      if (m_pend) begin
        chk("model_sum", int'(out_sum), int'(m_sum12));
        chk("model_ovf", int'(out_ovf), int'(m_ovf12));
        chk("model_cnt", int'(out_cnt), int'(m_cnt));
        chk("model_sum9", int'(out_sum9), int'(m_sum9));
        chk("model_ovf9", int'(out_ovf9), int'(m_ovf9));
        chk("model_cnt9", int'(out_cnt9), int'(m_cnt));
      end
    end
    if (rst) begin
      m_pend  = 1'b0;
      m_grp.delete();
      m_known = 1'b1;
    end else if (m_known) begin
      if (!m_pend) begin
        if (in_valid) begin
          m_grp.push_back(int'(in_prod));
          if (in_last || m_grp.size() == LEN) begin
            group_result(12, m_sum12, m_ovf12);
            group_result(9, m_sum9, m_ovf9);
            m_cnt  = m_grp.size();
            m_pend = 1'b1;
            m_grp.delete();
          end
        end
      end else if (out_ready) begin
        m_pend = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] p, input logic l);
    in_valid = 1'b1;
    in_prod  = p;
    in_last  = l;
    cyc();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    out_ready = 1'b1;
    for (int j = 0; j < int'(v.n); j++) send(v.prod[j], v.last[j]);
    chk($sformatf("vec%0d_valid", idx), int'(out_valid), 1);
    chk($sformatf("vec%0d_sum", idx), int'(out_sum), int'(v.sum));
    chk($sformatf("vec%0d_ovf", idx), int'(out_ovf), int'(v.ovf));
    chk($sformatf("vec%0d_cnt", idx), int'(out_cnt), int'(v.cnt));
    chk($sformatf("vec%0d_sum9", idx), int'(out_sum9), int'(v.sum9));
    chk($sformatf("vec%0d_ovf9", idx), int'(out_ovf9), int'(v.ovf9));
    cyc();
    chk($sformatf("vec%0d_ready_after", idx), int'(in_ready), 1);
  endtask

  initial begin
    int pat[7];
    int k;
    vecs[0] = '{3'd4, {8'd80, 8'd24, 8'd9, 8'd6}, 4'b0000, 12'd119, 1'b0, 3'd4, 9'd119, 1'b0};
    vecs[1] = '{3'd4, {8'd196, 8'd196, 8'd196, 8'd196}, 4'b0000, 12'd784, 1'b0, 3'd4,
                9'd272, 1'b1};
    vecs[2] = '{3'd2, {8'd0, 8'd0, 8'd30, 8'd15}, 4'b0010, 12'd45, 1'b0, 3'd2, 9'd45, 1'b0};
    vecs[3] = '{3'd1, {8'd0, 8'd0, 8'd0, 8'd77}, 4'b0001, 12'd77, 1'b0, 3'd1, 9'd77, 1'b0};
    vecs[4] = '{3'd4, {8'd255, 8'd255, 8'd255, 8'd255}, 4'b1000, 12'd1020, 1'b0, 3'd4,
                9'd508, 1'b1};
    vecs[5] = '{3'd3, {8'd0, 8'd200, 8'd100, 8'd250}, 4'b0100, 12'd550, 1'b0, 3'd3,
                9'd38, 1'b1};

    rst = 1'b1; in_valid = 1'b0; in_prod = '0; in_last = 1'b0; out_ready = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_sum", int'(out_sum), 0);
    chk("rst_out_ovf", int'(out_ovf), 0);
    chk("rst_out_cnt", int'(out_cnt), 0);

    for (int i = 0; i < 6; i++) apply_vec(vecs[i], i);

    // Gapped input: idle cycles carry junk products that must be ignored.
    pat = '{1, 0, 0, 1, 0, 1, 1};
    k = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = pat[i] != 0;
      in_prod  = (pat[i] != 0) ? 8'(k + 1) : 8'hAA;
      in_last  = 1'b0;
      if (pat[i] != 0) k++;
      cyc();
    end
    in_valid = 1'b0;
    chk("gap_sum", int'(out_sum), 10);
    chk("gap_cnt", int'(out_cnt), 4);
    cyc();

    // Backpressure: result held while upstream keeps offering products.
    out_ready = 1'b1;
    send(8'd6, 1'b0); send(8'd9, 1'b0); send(8'd24, 1'b0);
    out_ready = 1'b0;
    send(8'd80, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_prod  = 8'(200 + i);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_sum", int'(out_sum), 119);
      chk("bp_cnt", int'(out_cnt), 4);
      cyc();
    end
    out_ready = 1'b1;
    in_prod   = 8'd99;
    cyc();
    chk("bp_ready_after", int'(in_ready), 1);
    send(8'd1, 1'b0); send(8'd2, 1'b0); send(8'd3, 1'b1);
    chk("bp_next_sum", int'(out_sum), 6);
    chk("bp_next_cnt", int'(out_cnt), 3);
    cyc();

    // Reset mid-group discards the partial sum.
    send(8'd25, 1'b0); send(8'd25, 1'b0);
    rst = 1'b1; in_valid = 1'b1; in_prod = 8'd5;
    cyc();
    rst = 1'b0; in_valid = 1'b0;
    chk("rstmid_valid", int'(out_valid), 0);
    for (int i = 0; i < 4; i++) send(8'd1, 1'b0);
    chk("rstmid_sum", int'(out_sum), 4);
    chk("rstmid_cnt", int'(out_cnt), 4);
    chk("rstmid_ovf", int'(out_ovf), 0);
    cyc();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 59) == 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      in_prod   = 8'($urandom_range(0, 255));
      in_last   = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 1) != 0);
      cyc();
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cyc();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
